process_scheduler: RTL and testbench
====================================

# process_scheduler

Deterministic single-threaded scheduler for the chip's instruction-executing processes. It grants exactly one process per clock in a fixed round-robin order. It counts steps (one full sweep of the processes) and detects global halt or step-limit timeout. It produces the chip-level return code. It sits between the chip top level and the per-process `case(pc)` datapaths, and replaces the testbench-driven `processCurrent` sequencing, so that Java and Verilog runs stay cycle-identical.

## Interface
- `N_PROC`, 4, number of processes scheduled (1..16)
- `MAX_STEPS`, 100, step limit; reaching it ends the run with timeout
- `RC_W`, 8, width of each process return code
- `IDX_W`, `$clog2(N_PROC)` (minimum 1), width of the process index
- `clock`  in  1  single clock; all state changes on the posedge
- `reset`  in  1  asynchronous, active-high; forces IDLE immediately
- `start`  in  1  begin a run; sampled only in IDLE or DONE
- `proc_stop`  in  N_PROC  bit i high means process i has stopped (default case reached)
- `proc_rc`  in  N_PROC*RC_W  return code of process i in bits [i*RC_W +: RC_W]
- `proc_init`  out  1  one-cycle pulse; processes clear pc, stop, rc and registers (step -1)
- `proc_enable`  out  N_PROC  one-hot grant; process i executes one instruction on a posedge where bit i is high
- `proc_current`  out  IDX_W  index of the granted process
- `step`  out  32  completed-step counter
- `step_pulse`  out  1  high for one cycle after each step completes (trace/print hook)
- `running`  out  1  high in RUN
- `done`  out  1  high in DONE
- `timeout`  out  1  high in DONE when the run ended on the step limit
- `return_code`  out  RC_W  final chip return code, valid while `done`

## Operation
- All outputs are registered. Reset value of every output is 0; state is IDLE.
- States:
  - IDLE: outputs 0. `start` leads to INIT.
  - INIT: `proc_init`=1 for exactly one cycle. Then step=0, `proc_current`=first eligible index (0 without skip), and the state goes to RUN.
  - RUN: `proc_enable`=1<<`proc_current`, `running`=1.
    - Each cycle the scheduler computes next = the next index after `proc_current` in ascending order, wrapping at N_PROC-1.
    - With skip enabled (see Configuration), stopped indices are passed over.
    - Wrap (next index ≤ current index, or N_PROC=1) completes a step: step+1, `step_pulse`=1 next cycle.
  - DONE: `proc_enable`=0, `running`=0, `done`=1. `start` leads to INIT, which clears step, `timeout` and `return_code`.
- Termination is checked each RUN cycle using `proc_stop` sampled that cycle:
  - all `proc_stop` bits high: go to DONE, `timeout`=0. `return_code` = rc of the lowest-index process with nonzero rc, else 0.
  - otherwise, if a step completes and the new step == MAX_STEPS: go to DONE, `timeout`=1, `return_code`=0.
  - both in the same cycle: halt wins (`timeout`=0).
- `start` is ignored in INIT and RUN.
- Reset mid-run: immediate IDLE, all outputs 0. `proc_init` is not issued until the next `start`.
- step saturates at 2^32-1. It cannot be reached with a legal MAX_STEPS.

## Timing
- `start` sampled at edge k: `proc_init` high in cycle k+1; first grant in cycle k+2.
- The grant for cycle c is visible after edge c-1. The process acts at edge c.
- Throughput is one instruction per clock across the chip.
- `step_pulse` is asserted in the cycle after the wrap edge, concurrent with the first grant of the next step.
- DONE is entered on the edge after the terminating condition is sampled. The grant in the terminating cycle still executes.

## Configuration
- `SCHED_SKIP_STOPPED_EN` defined: stopped processes receive no grant. A step is one sweep of the live processes only. If the current process stops, the next grant goes to the next live index.
- Not defined: every index 0..N_PROC-1 is granted every step regardless of `proc_stop`, so each step is exactly N_PROC cycles. This matches the Java reference stepping exactly and is the default build.

## Test plan
- N_PROC=1, MAX_STEPS=100; process stops after 16 grants -> `done`=1 at step 16, `timeout`=0, `return_code`=0, `proc_enable`=1 for exactly 16 cycles.
- N_PROC=4, no skip, no process stops -> `proc_current` sequence 0,1,2,3,0,...; `step_pulse` every 4 cycles; `timeout`=1 with step=100 after 400 grants.
- N_PROC=4 with `SCHED_SKIP_STOPPED_EN`; process 1 stops at step 2 -> sequence becomes 0,2,3,0,2,3; steps take 3 cycles.
- All processes stop; proc_rc = {0,5,3,0} (idx3..0) -> `return_code`=3 (index 1 has rc 3, the lowest nonzero index), `done`=1.
- Last stop and the MAX_STEPS wrap land in the same cycle -> `timeout`=0, `done`=1.
- Reset asserted mid-RUN at step 7 -> all outputs 0 asynchronously. A following `start` produces `proc_init` and restarts at step 0, index 0.

Source files
------------

// File: rtl/process_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : process_scheduler_if
// Description : Grant/status bundle between the scheduler and the per-process
//               datapaths. master = scheduler side, slave = process side.
// Revision    : 1.0 - initial release
// ============================================================================
interface process_scheduler_if #(
    parameter int N_PROC = 4,
    parameter int RC_W   = 8,
    parameter int IDX_W  = (N_PROC > 1) ? $clog2(N_PROC) : 1
) ();
    logic                     proc_init;
    logic [N_PROC-1:0]        proc_enable;
    logic [IDX_W-1:0]         proc_current;
    logic [N_PROC-1:0]        proc_stop;
    logic [N_PROC*RC_W-1:0]   proc_rc;

    modport master (
        output proc_init, proc_enable, proc_current,
        input  proc_stop, proc_rc
    );

    modport slave (
        input  proc_init, proc_enable, proc_current,
        output proc_stop, proc_rc
    );
endinterface
`default_nettype wire

// File: rtl/process_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : process_scheduler
// Description : Fixed round-robin one-grant-per-clock process scheduler with
//               step counting, halt/step-limit detection and return code.
//               Optional macro SCHED_SKIP_STOPPED_EN: stopped processes are
//               passed over instead of granted.
// Revision    : 1.0 - initial release
// ============================================================================
module process_scheduler #(
    parameter int N_PROC    = 4,
    parameter int MAX_STEPS = 100,
    parameter int RC_W      = 8,
    parameter int IDX_W     = (N_PROC > 1) ? $clog2(N_PROC) : 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    process_scheduler_if.master  bus,
    output logic [31:0]          step,
    output logic                 step_pulse,
    output logic                 running,
    output logic                 done,
    output logic                 timeout,
    output logic [RC_W-1:0]      return_code
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_INIT = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_q,   state_d;
    logic [IDX_W-1:0]  cur_q,     cur_d;
    logic [N_PROC-1:0] enable_q,  enable_d;
    logic              init_q,    init_d;
    logic [31:0]       step_q,    step_d;
    logic              pulse_q,   pulse_d;
    logic              running_q, running_d;
    logic              done_q,    done_d;
    logic              timeout_q, timeout_d;
    logic [RC_W-1:0]   rc_q,      rc_d;

    logic [IDX_W-1:0]  next_idx;
    logic              wrap;
    logic              all_stop;
    logic [RC_W-1:0]   rc_low;
    logic [31:0]       step_inc;

`ifdef SCHED_SKIP_STOPPED_EN
    int                cand;
    logic [IDX_W-1:0]  cand_idx;
    logic              found;

    // Search forward from cur+1, wrapping; cur itself is the last candidate.
    always_comb begin
        next_idx = '0;
        cand     = 0;
        cand_idx = '0;
        found    = 1'b0;
        for (int k = 1; k <= N_PROC; k++) begin
            cand = int'(cur_q) + k;
            if (cand >= N_PROC)
                cand = cand - N_PROC;
            cand_idx = IDX_W'(cand);
            if (!found && !bus.proc_stop[cand_idx]) begin
                next_idx = cand_idx;
                found    = 1'b1;
            end
        end
        wrap = (next_idx <= cur_q);
    end
`else
    always_comb begin
        wrap     = (int'(cur_q) == N_PROC - 1);
        next_idx = wrap ? '0 : cur_q + IDX_W'(1);
    end
`endif

    assign all_stop = &bus.proc_stop;
    assign step_inc = (step_q == 32'hFFFF_FFFF) ? step_q : step_q + 32'd1;

    // Descending scan so the lowest nonzero index is the one left standing.
    always_comb begin
        rc_low = '0;
        for (int i = N_PROC - 1; i >= 0; i--) begin
            if (bus.proc_rc[i*RC_W +: RC_W] != '0)
                rc_low = bus.proc_rc[i*RC_W +: RC_W];
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        enable_d  = enable_q;
        init_d    = 1'b0;
        step_d    = step_q;
        pulse_d   = 1'b0;
        running_d = running_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        rc_d      = rc_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_INIT;
                    init_d    = 1'b1;
                    step_d    = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    rc_d      = '0;
                end
            end
            S_INIT: begin
                // proc_init clears every stop flag, so index 0 is always live here.
                state_d     = S_RUN;
                step_d      = '0;
                cur_d       = '0;
                enable_d    = '0;
                enable_d[0] = 1'b1;
                running_d   = 1'b1;
            end
            S_RUN: begin
                if (wrap) begin
                    step_d  = step_inc;
                    pulse_d = 1'b1;
                end
                if (all_stop || (wrap && step_inc == 32'(MAX_STEPS))) begin
                    state_d   = S_DONE;
                    enable_d  = '0;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    timeout_d = !all_stop;
                    rc_d      = all_stop ? rc_low : '0;
                end else begin
                    cur_d            = next_idx;
                    enable_d         = '0;
                    enable_d[next_idx] = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cur_q     <= '0;
            enable_q  <= '0;
            init_q    <= 1'b0;
            step_q    <= '0;
            pulse_q   <= 1'b0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            rc_q      <= '0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            enable_q  <= enable_d;
            init_q    <= init_d;
            step_q    <= step_d;
            pulse_q   <= pulse_d;
            running_q <= running_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            rc_q      <= rc_d;
        end
    end

    assign bus.proc_init    = init_q;
    assign bus.proc_enable  = enable_q;
    assign bus.proc_current = cur_q;
    assign step             = step_q;
    assign step_pulse       = pulse_q;
    assign running          = running_q;
    assign done             = done_q;
    assign timeout          = timeout_q;
    assign return_code      = rc_q;
endmodule
`default_nettype wire

// File: tb/tb_process_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_process_scheduler
// Description : Directed self-checking bench: one single-process and one
//               four-process scheduler instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_process_scheduler;
    logic        clock = 1'b0;
    logic        reset;
    logic        start1, start4;
    logic [31:0] step1, step4;
    logic        pulse1, pulse4, run1, run4, done1, done4, to1, to4;
    logic [7:0]  rc1, rc4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    process_scheduler_if #(.N_PROC(1), .RC_W(8), .IDX_W(1)) bus1 ();
    process_scheduler_if #(.N_PROC(4), .RC_W(8), .IDX_W(2)) bus4 ();

    process_scheduler #(.N_PROC(1), .MAX_STEPS(100), .RC_W(8), .IDX_W(1)) u_dut1 (
        .clock(clock), .reset(reset), .start(start1), .bus(bus1),
        .step(step1), .step_pulse(pulse1), .running(run1), .done(done1),
        .timeout(to1), .return_code(rc1)
    );

    process_scheduler #(.N_PROC(4), .MAX_STEPS(100), .RC_W(8), .IDX_W(2)) u_dut4 (
        .clock(clock), .reset(reset), .start(start4), .bus(bus4),
        .step(step4), .step_pulse(pulse4), .running(run4), .done(done4),
        .timeout(to4), .return_code(rc4)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int cnt, grants, pulses, pulse_err, seq_err;
    int seq[6];
`ifdef SCHED_SKIP_STOPPED_EN
    int exp_seq[6] = '{0, 2, 3, 0, 2, 3};
    int exp_step_after = 4;
`else
    int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
    int exp_step_after = 3;
`endif

    initial begin
        reset = 1'b1;
        start1 = 1'b0;
        start4 = 1'b0;
        bus1.proc_stop = '0;
        bus1.proc_rc   = '0;
        bus4.proc_stop = '0;
        bus4.proc_rc   = '0;
        tick();
        tick();
        check_val("rst_enable", 32'(bus4.proc_enable), 0);
        check_val("rst_init", 32'(bus4.proc_init), 0);
        check_val("rst_step", step4, 0);
        check_val("rst_done", 32'(done4), 0);
        reset = 1'b0;
        tick();

        // Single process: stop seen during its 16th grant
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check_val("n1_init_hi", 32'(bus1.proc_init), 1);
        tick();
        check_val("n1_init_lo", 32'(bus1.proc_init), 0);
        check_val("n1_first_step", step1, 0);
        cnt = bus1.proc_enable[0] ? 1 : 0;
        for (int c = 0; c < 100 && !done1; c++) begin
            if (cnt >= 16) bus1.proc_stop = 1'b1;
            tick();
            if (bus1.proc_enable[0]) cnt++;
        end
        check_val("n1_done", 32'(done1), 1);
        check_val("n1_grants", cnt, 16);
        check_val("n1_step", step1, 16);
        check_val("n1_timeout", 32'(to1), 0);
        check_val("n1_rc", 32'(rc1), 0);
        check_val("n1_running", 32'(run1), 0);

        // Four processes, none stop: step limit
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check_val("t2_init", 32'(bus4.proc_init), 1);
        grants = 0; pulses = 0; pulse_err = 0; seq_err = 0;
        for (int c = 0; c < 1000 && !done4; c++) begin
            tick();
            if (pulse4) pulses++;
            if (bus4.proc_enable != 4'b0) begin
                if (pulse4 !== (bus4.proc_current == 2'd0 && grants > 0)) pulse_err++;
                if (int'(bus4.proc_current) != grants % 4) seq_err++;
                if (bus4.proc_enable != (4'b0001 << (grants % 4))) seq_err++;
                grants++;
            end
        end
        check_val("t2_done", 32'(done4), 1);
        check_val("t2_timeout", 32'(to4), 1);
        check_val("t2_step", step4, 100);
        check_val("t2_grants", grants, 400);
        check_val("t2_pulses", pulses, 100);
        check_val("t2_pulse_align", pulse_err, 0);
        check_val("t2_sequence", seq_err, 0);
        check_val("t2_rc", 32'(rc4), 0);

        // All stop while index 1 is granted; rc idx3..0 = {0,5,3,0}
        bus4.proc_rc = {8'd0, 8'd5, 8'd3, 8'd0};
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check_val("t3_init", 32'(bus4.proc_init), 1);
        check_val("t3_step_clr", step4, 0);
        check_val("t3_timeout_clr", 32'(to4), 0);
        check_val("t3_done_clr", 32'(done4), 0);
        check_val("t3_rc_clr", 32'(rc4), 0);
        tick();
        check_val("t3_cur0", 32'(bus4.proc_current), 0);
        tick();
        check_val("t3_cur1", 32'(bus4.proc_current), 1);
        bus4.proc_stop = 4'hF;
        tick();
        check_val("t3_done", 32'(done4), 1);
        check_val("t3_timeout", 32'(to4), 0);
        check_val("t3_rc", 32'(rc4), 3);
        check_val("t3_step", step4, 0);
        check_val("t3_enable", 32'(bus4.proc_enable), 0);

        // Last stop coincides with the step-limit wrap: halt wins
        bus4.proc_stop = 4'h0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        for (int c = 0; c < 1000 && !done4; c++) begin
            if (step4 == 99 && bus4.proc_current == 2'd3 && run4) bus4.proc_stop = 4'hF;
            tick();
        end
        check_val("t4_done", 32'(done4), 1);
        check_val("t4_timeout", 32'(to4), 0);
        check_val("t4_step", step4, 100);
        check_val("t4_rc", 32'(rc4), 3);

        // Asynchronous reset at step 7, then restart
        bus4.proc_stop = 4'h0;
        bus4.proc_rc   = '0;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        tick();
        for (int c = 0; c < 100 && step4 != 7; c++) tick();
        check_val("t5_reach7", step4, 7);
        #2 reset = 1'b1;
        #1;
        check_val("t5_rst_enable", 32'(bus4.proc_enable), 0);
        check_val("t5_rst_running", 32'(run4), 0);
        check_val("t5_rst_step", step4, 0);
        check_val("t5_rst_cur", 32'(bus4.proc_current), 0);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check_val("t5_idle_init", 32'(bus4.proc_init), 0);
        check_val("t5_idle_running", 32'(run4), 0);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check_val("t5_init", 32'(bus4.proc_init), 1);
        tick();
        check_val("t5_step0", step4, 0);
        check_val("t5_cur0", 32'(bus4.proc_current), 0);
        check_val("t5_enable", 32'(bus4.proc_enable), 1);

        // Process 1 stops at the start of step 2
        for (int c = 0; c < 100 && step4 != 2; c++) tick();
        check_val("t6_reach2", step4, 2);
        bus4.proc_stop = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            seq[i] = int'(bus4.proc_current);
            tick();
        end
        for (int i = 0; i < 6; i++)
            check_val($sformatf("t6_seq%0d", i), seq[i], exp_seq[i]);
        check_val("t6_step_after", step4, exp_step_after);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
